// File: rtl/sd_arb_pkg.sv
// Shared types and the round-robin selection rule for the SD request arbiter.
package sd_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        HOLD
    } arb_state_t;

    // First pending index strictly after last, wrapping modulo nreq; last itself has lowest priority.
    function automatic req_idx_t rr_pick(input logic [MAX_REQ-1:0] pending,
                                         input req_idx_t last,
                                         input int nreq);
        req_idx_t pick;
        int       idx;
        pick = last;
        for (int k = MAX_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % nreq;
            if (k <= nreq && pending[idx[1:0]]) begin
                pick = req_idx_t'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin priority encoder over NREQ request lines.
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      last,
    output logic [1:0]      pick,
    output logic            valid
);

    logic [MAX_REQ-1:0] pend_ext;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pend_ext             = '0;
        pend_ext[NREQ-1:0]   = pending;
    end

    assign pick  = rr_pick(pend_ext, last, NREQ);
    assign valid = |pending;

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares hps_io's single SD block channel among NREQ disk controllers, one transfer at a time,
// round-robin granted, with an ack-rise timeout that aborts a stuck request.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WIDE    = 0,
    parameter int TIMEOUT = 2**24
) (
    input  logic                                 clk_sys,
    input  logic                                 reset_n,
    input  logic [32*NREQ-1:0]                   req_lba,
    input  logic [NREQ-1:0]                      req_rd,
    input  logic [NREQ-1:0]                      req_wr,
    output logic [NREQ-1:0]                      req_ack,
    output logic [NREQ-1:0]                      req_done,
    output logic [NREQ-1:0]                      req_err,
    output logic [NREQ-1:0]                      req_buff_wr,
    input  logic [((WIDE != 0) ? 16 : 8)*NREQ-1:0] req_buff_din,
    output logic [31:0]                          sd_lba,
    output logic [NREQ-1:0]                      sd_rd,
    output logic [NREQ-1:0]                      sd_wr,
    input  logic                                 sd_ack,
    input  logic                                 sd_buff_wr,
    output logic [((WIDE != 0) ? 16 : 8)-1:0]    sd_buff_din
);

    localparam int BW = (WIDE != 0) ? 16 : 8;
    localparam int TW = $clog2(TIMEOUT);

    arb_state_t      state;
    arb_state_t      state_nxt;
    req_idx_t        grant;
    req_idx_t        last;
    req_idx_t        pick;
    logic            pick_valid;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] pick_oh;
    logic [31:0]     pick_lba;
    logic            pick_rd;
    logic [TW-1:0]   timer;
    logic            ack_low;
    logic            ack_start;
    logic            timeout_hit;
    logic            active;

    function automatic logic [NREQ-1:0] to_onehot(input req_idx_t idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_idx_t'(i) == idx) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    sd_rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (req_rd | req_wr),
        .last    (last),
        .pick    (pick),
        .valid   (pick_valid)
    );

    assign grant_oh    = to_onehot(grant);
    assign pick_oh     = to_onehot(pick);
    assign pick_rd     = |(req_rd & pick_oh);
    // A stale ack left high from a previous transfer must not count; ack_low proves a fresh rise.
    assign ack_start   = ack_low & sd_ack;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    assign active      = (state != IDLE);

    always_comb begin
        pick_lba = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_lba = req_lba[32*i +: 32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pick_valid) state_nxt = REQ;
            REQ: begin
                if (ack_start)        state_nxt = XFER;
                else if (timeout_hit) state_nxt = IDLE;
            end
            XFER: if (!sd_ack) state_nxt = HOLD;
            HOLD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ack     = active ? (grant_oh & {NREQ{sd_ack}})     : '0;
        req_buff_wr = active ? (grant_oh & {NREQ{sd_buff_wr}}) : '0;
        sd_buff_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (active && grant_oh[i]) sd_buff_din = req_buff_din[BW*i +: BW];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= '0;
            last     <= req_idx_t'(NREQ - 1);
            sd_lba   <= '0;
            sd_rd    <= '0;
            sd_wr    <= '0;
            req_done <= '0;
            req_err  <= '0;
            timer    <= '0;
            ack_low  <= 1'b0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick;
                        sd_lba  <= pick_lba;
                        sd_rd   <= pick_rd ? pick_oh : '0;
                        sd_wr   <= pick_rd ? '0 : pick_oh;
                        timer   <= '0;
                        ack_low <= 1'b0;
                    end
                end
                REQ: begin
                    timer <= timer + TW'(1);
                    if (!sd_ack) ack_low <= 1'b1;
                    if (ack_start) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                    end else if (timeout_hit) begin
                        sd_rd   <= '0;
                        sd_wr   <= '0;
                        req_err <= grant_oh;
                        last    <= grant;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        req_done <= grant_oh;
                        last     <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: directed scenarios plus a randomized round-robin run
// checked against a queue-free arithmetic model of the grant order.
module tb_sd_req_arbiter;

    localparam int NREQ    = 2;
    localparam int WIDE    = 0;
    localparam int TIMEOUT = 100;
    localparam int BW      = 8;

    logic                 clk_sys = 1'b0;
    logic                 reset_n;
    logic [32*NREQ-1:0]   req_lba;
    logic [NREQ-1:0]      req_rd;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic [NREQ-1:0]      req_buff_wr;
    logic [BW*NREQ-1:0]   req_buff_din;
    logic [31:0]          sd_lba;
    logic [NREQ-1:0]      sd_rd;
    logic [NREQ-1:0]      sd_wr;
    logic                 sd_ack;
    logic                 sd_buff_wr;
    logic [BW-1:0]        sd_buff_din;

    int checks   = 0;
    int failures = 0;

    // Reference model: request levels, per-requester data, and the last requester served.
    logic [NREQ-1:0] m_rd;
    logic [NREQ-1:0] m_wr;
    logic [31:0]     m_lba [NREQ];
    logic [BW-1:0]   m_din [NREQ];
    int              m_last;

    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter #(.NREQ(NREQ), .WIDE(WIDE), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_buff_wr  (req_buff_wr),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    task automatic apply_reqs();
        req_rd = m_rd;
        req_wr = m_wr;
        for (int i = 0; i < NREQ; i++) begin
            req_lba[32*i +: 32]      = m_lba[i];
            req_buff_din[BW*i +: BW] = m_din[i];
        end
    endtask

    // Next requester after m_last (wrapping) that has any request level up.
    function automatic int model_pick();
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (m_rd[idx] || m_wr[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n    = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        m_rd       = '0;
        m_wr       = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_lba[i] = 32'h0;
            m_din[i] = '0;
        end
        apply_reqs();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        m_last  = NREQ - 1;
        @(negedge clk_sys);
    endtask

    // Plays hps_io for one transfer expected on requester idx.
    task automatic serve(input int idx, input bit is_wr, input int ack_delay, input int ack_len);
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] exp_rd;
        logic [NREQ-1:0] exp_wr;
        logic [NREQ-1:0] exp_bw;
        int              waited;
        bit              seen;
        oh     = NREQ'(1 << idx);
        exp_rd = is_wr ? '0 : oh;
        exp_wr = is_wr ? oh : '0;
        waited = 0;
        while ((sd_rd | sd_wr) == '0 && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        checks++;
        if (sd_rd !== exp_rd || sd_wr !== exp_wr) begin
            failures++;
            $display("FAIL serve_grant req=%0d: sd_rd=%b sd_wr=%b expected sd_rd=%b sd_wr=%b",
                     idx, sd_rd, sd_wr, exp_rd, exp_wr);
        end
        checks++;
        if (sd_lba !== m_lba[idx]) begin
            failures++;
            $display("FAIL serve_lba req=%0d: sd_lba=%h expected %h", idx, sd_lba, m_lba[idx]);
        end
        repeat (ack_delay) @(negedge clk_sys);
        sd_ack = 1'b1;
        for (int j = 0; j < ack_len; j++) begin
            sd_buff_wr = 1'($urandom_range(0, 1));
            #1;
            exp_bw = sd_buff_wr ? oh : '0;
            checks++;
            if (req_ack !== oh || req_buff_wr !== exp_bw) begin
                failures++;
                $display("FAIL serve_strobes req=%0d: req_ack=%b req_buff_wr=%b expected %b %b",
                         idx, req_ack, req_buff_wr, oh, exp_bw);
            end
            if (is_wr) begin
                checks++;
                if (sd_buff_din !== m_din[idx]) begin
                    failures++;
                    $display("FAIL serve_din req=%0d: sd_buff_din=%h expected %h",
                             idx, sd_buff_din, m_din[idx]);
                end
            end
            @(negedge clk_sys);
        end
        checks++;
        if (sd_rd !== '0 || sd_wr !== '0) begin
            failures++;
            $display("FAIL serve_xfer_idle req=%0d: sd_rd=%b sd_wr=%b expected 0 0", idx, sd_rd, sd_wr);
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        seen       = 1'b0;
        waited     = 0;
        while (!seen && waited < 5) begin
            @(negedge clk_sys);
            waited++;
            if (req_done !== '0) seen = 1'b1;
        end
        checks++;
        if (req_done !== oh || req_err !== '0) begin
            failures++;
            $display("FAIL serve_done req=%0d: req_done=%b req_err=%b expected %b 0",
                     idx, req_done, req_err, oh);
        end
    endtask

    task automatic test_reset();
        do_reset();
        m_din[0]   = 8'h5A;
        m_din[1]   = 8'hC3;
        apply_reqs();
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        checks++;
        if (sd_rd !== '0 || sd_wr !== '0 || sd_lba !== 32'h0) begin
            failures++;
            $display("FAIL reset_sd: sd_rd=%b sd_wr=%b sd_lba=%h expected 0", sd_rd, sd_wr, sd_lba);
        end
        checks++;
        if (req_done !== '0 || req_err !== '0 || req_ack !== '0 || req_buff_wr !== '0) begin
            failures++;
            $display("FAIL reset_req: done=%b err=%b ack=%b bw=%b expected 0",
                     req_done, req_err, req_ack, req_buff_wr);
        end
        checks++;
        if (sd_buff_din !== '0) begin
            failures++;
            $display("FAIL reset_din: sd_buff_din=%h expected 0", sd_buff_din);
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m_rd[0]  = 1'b1;
        m_lba[0] = 32'h0000_1234;
        apply_reqs();
        @(negedge clk_sys);
        checks++;
        if (sd_rd !== 2'b01 || sd_lba !== 32'h1234) begin
            failures++;
            $display("FAIL single_issue: sd_rd=%b sd_lba=%h expected 01 00001234", sd_rd, sd_lba);
        end
        serve(0, 1'b0, 2, 512);
        m_rd[0] = 1'b0;
        apply_reqs();
        @(negedge clk_sys);
        checks++;
        if (req_done !== '0 || sd_rd !== '0) begin
            failures++;
            $display("FAIL single_pulse: req_done=%b sd_rd=%b expected 0 0", req_done, sd_rd);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m_rd     = 2'b11;
        m_lba[0] = $urandom;
        m_lba[1] = $urandom;
        apply_reqs();
        serve(0, 1'b0, 1, 6);
        m_rd[0] = 1'b0;
        apply_reqs();
        serve(1, 1'b0, 3, 6);
        m_rd[1] = 1'b0;
        apply_reqs();
    endtask

    task automatic test_write_data();
        do_reset();
        m_wr[1]  = 1'b1;
        m_lba[1] = 32'hDEAD_0001;
        m_din[0] = 8'h3C;
        m_din[1] = 8'hA5;
        apply_reqs();
        serve(1, 1'b1, 2, 24);
        m_wr[1] = 1'b0;
        apply_reqs();
    endtask

    task automatic test_timeout();
        int cnt;
        int waited;
        do_reset();
        m_rd[0]  = 1'b1;
        m_lba[0] = 32'h0000_0077;
        apply_reqs();
        cnt    = 0;
        waited = 0;
        @(negedge clk_sys);
        while (sd_rd !== '0 && waited < 3*TIMEOUT) begin
            cnt++;
            @(negedge clk_sys);
            waited++;
        end
        checks++;
        if (cnt != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_len: sd_rd high %0d cycles expected %0d", cnt, TIMEOUT);
        end
        checks++;
        if (req_err !== 2'b01 || req_done !== '0) begin
            failures++;
            $display("FAIL timeout_err: req_err=%b req_done=%b expected 01 00", req_err, req_done);
        end
        m_rd[0] = 1'b0;
        apply_reqs();
        @(negedge clk_sys);
        checks++;
        if (req_err !== '0 || sd_rd !== '0) begin
            failures++;
            $display("FAIL timeout_pulse: req_err=%b sd_rd=%b expected 0 0", req_err, sd_rd);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        do_reset();
        m_rd[0]  = 1'b1;
        m_lba[0] = 32'h0BAD_F00D;
        apply_reqs();
        waited = 0;
        while (sd_rd === '0 && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (req_ack !== 2'b01 || sd_rd !== '0) begin
            failures++;
            $display("FAIL midreset_xfer: req_ack=%b sd_rd=%b expected 01 00", req_ack, sd_rd);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (sd_rd !== '0 || sd_wr !== '0 || req_ack !== '0 || sd_lba !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs: sd_rd=%b sd_wr=%b req_ack=%b sd_lba=%h expected 0",
                     sd_rd, sd_wr, req_ack, sd_lba);
        end
        m_rd   = '0;
        apply_reqs();
        sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        m_last  = NREQ - 1;
        @(negedge clk_sys);
        m_rd[1]  = 1'b1;
        m_lba[1] = $urandom;
        apply_reqs();
        serve(1, 1'b0, 1, 8);
        m_rd[1] = 1'b0;
        apply_reqs();
    endtask

    task automatic test_stale_ack();
        do_reset();
        sd_ack   = 1'b1;
        m_rd[0]  = 1'b1;
        m_lba[0] = 32'h0000_5151;
        apply_reqs();
        repeat (6) @(negedge clk_sys);
        checks++;
        if (sd_rd !== 2'b01) begin
            failures++;
            $display("FAIL stale_ack_hold: sd_rd=%b expected 01", sd_rd);
        end
        sd_ack = 1'b0;
        serve(0, 1'b0, 1, 4);
        m_rd[0] = 1'b0;
        apply_reqs();
    endtask

    task automatic test_rd_wr_same();
        do_reset();
        m_rd[0]  = 1'b1;
        m_wr[0]  = 1'b1;
        m_lba[0] = 32'h0000_0606;
        m_din[0] = 8'h66;
        apply_reqs();
        serve(0, 1'b0, 1, 5);
        m_rd[0] = 1'b0;
        apply_reqs();
        serve(0, 1'b1, 2, 5);
        m_wr[0] = 1'b0;
        apply_reqs();
    endtask

    task automatic add_random_reqs(input bit force_one);
        bit op;
        for (int i = 0; i < NREQ; i++) begin
            if (!m_rd[i] && !m_wr[i] && (force_one || $urandom_range(0, 2) != 0)) begin
                op       = 1'($urandom_range(0, 1));
                m_rd[i]  = op;
                m_wr[i]  = ~op | 1'($urandom_range(0, 3) == 0);
                m_lba[i] = $urandom;
                m_din[i] = BW'($urandom);
            end
        end
    endtask

    task automatic test_random();
        int  exp_idx;
        bit  exp_wr;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ((m_rd | m_wr) == '0) begin
                add_random_reqs(1'b1);
                apply_reqs();
            end
            exp_idx = model_pick();
            exp_wr  = !m_rd[exp_idx];
            serve(exp_idx, exp_wr, $urandom_range(1, 4), $urandom_range(1, 16));
            if (exp_wr) m_wr[exp_idx] = 1'b0;
            else        m_rd[exp_idx] = 1'b0;
            m_last = exp_idx;
            add_random_reqs(1'b0);
            apply_reqs();
        end
        while ((m_rd | m_wr) != '0) begin
            exp_idx = model_pick();
            exp_wr  = !m_rd[exp_idx];
            serve(exp_idx, exp_wr, 1, 3);
            if (exp_wr) m_wr[exp_idx] = 1'b0;
            else        m_rd[exp_idx] = 1'b0;
            m_last = exp_idx;
            apply_reqs();
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        req_rd       = '0;
        req_wr       = '0;
        req_lba      = '0;
        req_buff_din = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_data();
        test_timeout();
        test_reset_mid();
        test_stale_ack();
        test_rd_wr_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
